// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with fixed latency, HI/LO registers and busy for hazard stalls
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        flush,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N1 = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_N1  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [31:0] phi, plo;
  logic        accept, load_p, commit, wr_hi, wr_lo;

  logic [63:0] prod;
  logic        sdiv;
  logic [31:0] dvd, dvs, dvs_safe, quo, rem, quo_res, rem_res;
  logic [31:0] res_hi, res_lo;

  assign accept = start && !flush && (state == IDLE);
  assign busy   = (state == RUN) || (accept && !op[2]);

  // Signed divide works on magnitudes so the 0x80000000 / -1 case needs no special path.
  always_comb begin
    prod     = op[0] ? ({32'b0, a} * {32'b0, b})
                     : ({{32{a[31]}}, a} * {{32{b[31]}}, b});
    sdiv     = (op == 3'd2);
    dvd      = (sdiv && a[31]) ? (32'd0 - a) : a;
    dvs      = (sdiv && b[31]) ? (32'd0 - b) : b;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    quo      = dvd / dvs_safe;
    rem      = dvd % dvs_safe;
    quo_res  = (sdiv && (a[31] ^ b[31])) ? (32'd0 - quo) : quo;
    rem_res  = (sdiv && a[31]) ? (32'd0 - rem) : rem;
    if (!op[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end else if (b == 32'd0) begin
      // Divide by zero retires as a no-op on HI/LO; they cannot change during RUN.
      res_hi = hi;
      res_lo = lo;
    end else begin
      res_hi = rem_res;
      res_lo = quo_res;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_p    = 1'b0;
    commit    = 1'b0;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              load_p    = 1'b1;
              state_nxt = RUN;
              cnt_nxt   = op[1] ? DIV_N1 : MULT_N1;
            end
            3'd4:    wr_hi = 1'b1;
            3'd5:    wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      phi   <= 32'd0;
      plo   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_p) begin
        phi <= res_hi;
        plo <= res_lo;
      end
      if (commit) begin
        hi <= phi;
        lo <= plo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the five-stage pipeline's E stage. It executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo in one cycle, and holds the architectural HI/LO registers. It generates the `busy` indication that the hazard unit combines with the D-stage "is MDU instruction" decode to freeze PC/D and bubble E.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an MDU op; single-cycle pulse per instruction
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6–7 are no-ops
- flush  input  1  E-stage instruction is being cancelled (exception/interrupt in M); suppresses start this cycle
- a  input  32  rs operand (already forwarded)
- b  input  32  rt operand (already forwarded)
- busy  output  1  MDU occupied; combinational: run state OR accepted mult/div start this cycle
- hi  output  32  architectural HI register (read by mfhi)
- lo  output  32  architectural LO register (read by mflo)

## Operation
- Accepted start: start=1, flush=0, state IDLE. In RUN, start is ignored; the hazard unit guarantees that case does not arise.
- States: IDLE, RUN. 4-bit down-counter `cnt`.
- IDLE + accepted mult/multu/div/divu: compute the result from a/b at this edge into pending registers phi/plo. Load cnt = N−1 (N = MULT_CYCLES or DIV_CYCLES). Go to RUN.
- RUN: cnt decrements each edge. At the edge where cnt==0: hi←phi, lo←plo, go to IDLE.
- IDLE + accepted mthi: hi←a at that edge. mtlo: lo←a. busy is not asserted. State stays IDLE.
- op 6/7 or start=0: no effect.
- mult: {hi,lo} = signed(a)×signed(b), 64-bit. multu: unsigned 64-bit product.
- div: lo = quotient truncated toward zero. hi = remainder, which takes the sign of a. Special case 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b==0, div or divu): op still occupies DIV_CYCLES of busy. hi and lo keep their prior values; no X propagation.
- flush does not abort an op already in RUN; that op's instruction has already left E and must retire.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE, cnt=0, hi=0, lo=0, phi=plo=0, busy=0 immediately. A reset asserted in RUN abandons the op; no HI/LO write.
- busy is high in the start cycle (combinational) and for the N following cycles (RUN). Total high time is N+1 cycles.
- The cycle after busy drops, hi/lo show the new result. mfhi/mflo in D stall until then.
- mthi/mtlo: new value is visible on hi/lo the cycle after the start edge. busy stays 0.
- start with flush=1: no state change, busy=0 for that cycle.

## Test plan
- mult a=0xFFFFFFFF, b=0xFFFFFFFF (start at edge T) → busy=1 for cycles T..T+5; after edge T+5, hi=0, lo=1. With multu and the same operands → hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (−7), b=2 → busy for 11 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x11, lo=0x22 via mthi/mtlo (each visible after one edge, busy stays 0). Then divu b=0 → busy for 11 cycles; hi=0x11, lo=0x22 unchanged.
- Flush:
  - mult with start=1, flush=1 → busy=0, hi/lo unchanged.
  - flush=1 during RUN of an accepted mult → op completes normally.
- Second start (mult, a=3, b=3) pulsed during RUN of div 100/7 → ignored; final lo=14, hi=2.
- reset_n pulled low for 1 cycle at RUN cycle 3 of a mult → busy drops asynchronously, hi=lo=0. A subsequent mult 6×7 gives lo=42.
